// File: rtl/cpu_fpu_add_arbiter_if.sv
// Client and adder handshake bundle for the shared FPU adder arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface cpu_fpu_add_arbiter_if #(
  parameter int REQUESTERS = 2
) ();
  logic [REQUESTERS-1:0]    i_request;
  logic [REQUESTERS-1:0]    i_sub;
  logic [32*REQUESTERS-1:0] i_op1;
  logic [32*REQUESTERS-1:0] i_op2;
  logic [REQUESTERS-1:0]    o_ready;
  logic [31:0]              o_result;
  logic                     o_unit_request;
  logic [31:0]              o_unit_op1;
  logic [31:0]              o_unit_op2;
  logic                     i_unit_ready;
  logic [31:0]              i_unit_result;

  modport slave (
    input  i_request, i_sub, i_op1, i_op2, i_unit_ready, i_unit_result,
    output o_ready, o_result, o_unit_request, o_unit_op1, o_unit_op2
  );

  modport master (
    output i_request, i_sub, i_op1, i_op2, i_unit_ready, i_unit_result,
    input  o_ready, o_result, o_unit_request, o_unit_op1, o_unit_op2
  );
endinterface

// File: rtl/cpu_fpu_add_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP32 adder among several clients,
// with optional op2 negation so clients can subtract.
module cpu_fpu_add_arbiter #(
  parameter int REQUESTERS = 2
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  cpu_fpu_add_arbiter_if.slave    bus
);
  localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_UNIT, RESPOND, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [31:0]            op1_q, op1_d;
  logic [31:0]            op2_q, op2_d;
  logic                   unit_req_q, unit_req_d;
  logic [REQUESTERS-1:0]  ready_q, ready_d;
  logic [31:0]            result_q, result_d;

  logic [IDX_W-1:0]       pick;
  logic                   pick_valid;
  logic [31:0]            op1_sel;
  logic [31:0]            op2_sel;

  // Scan clients starting just after the last winner so every waiting request is eventually served.
  always_comb begin
    int idx;
    logic [IDX_W-1:0] cand;
    idx        = 0;
    cand       = '0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int i = 1; i <= REQUESTERS; i++) begin
      idx = int'(last_q) + i;
      if (idx >= REQUESTERS) idx = idx - REQUESTERS;
      cand = IDX_W'(idx);
      if (!pick_valid && bus.i_request[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  assign op1_sel = bus.i_op1[{pick, 5'b00000} +: 32];
  assign op2_sel = bus.i_op2[{pick, 5'b00000} +: 32];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    unit_req_d = unit_req_q;
    ready_d    = ready_q;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        // A still-high adder ready would complete the new operation instantly, so hold off.
        if (pick_valid && !bus.i_unit_ready) begin
          grant_d    = pick;
          last_d     = pick;
          op1_d      = op1_sel;
          op2_d      = {op2_sel[31] ^ bus.i_sub[pick], op2_sel[30:0]};
          unit_req_d = 1'b1;
          state_d    = WAIT_UNIT;
        end
      end
      WAIT_UNIT: begin
        if (bus.i_unit_ready) begin
          result_d   = bus.i_unit_result;
          unit_req_d = 1'b0;
          if (bus.i_request[grant_q]) begin
            ready_d = REQUESTERS'(1) << grant_q;
            state_d = RESPOND;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      RESPOND: begin
        if (!bus.i_request[grant_q]) begin
          ready_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!bus.i_unit_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IDX_W'(REQUESTERS - 1);
      op1_q      <= '0;
      op2_q      <= '0;
      unit_req_q <= 1'b0;
      ready_q    <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      unit_req_q <= unit_req_d;
      ready_q    <= ready_d;
      result_q   <= result_d;
    end
  end

  assign bus.o_ready        = ready_q;
  assign bus.o_result       = result_q;
  assign bus.o_unit_request = unit_req_q;
  assign bus.o_unit_op1     = op1_q;
  assign bus.o_unit_op2     = op2_q;
endmodule

// File: tb/tb_cpu_fpu_add_arbiter.sv
// Directed bench for cpu_fpu_add_arbiter: vector table of single operations plus
// hand-written sequences for contention, abandonment and mid-operation reset.
module tb_cpu_fpu_add_arbiter;
  localparam int REQUESTERS = 2;
  localparam int UNIT_LAT   = 3;

  logic i_clock = 1'b0;
  logic i_reset = 1'b0;

  cpu_fpu_add_arbiter_if #(.REQUESTERS(REQUESTERS)) bus ();

  cpu_fpu_add_arbiter #(.REQUESTERS(REQUESTERS)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clock = ~i_clock;

  int checks   = 0;
  int failures = 0;
  int order_q[$];

  typedef struct {
    int          client;
    logic        sub;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] exp_op2;
    logic [31:0] exp_result;
  } vec_t;

  vec_t vecs[5];
  int   exp_order[6];

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52];
    if (e == 11'd0) return {d[63], 31'd0};
    return {d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  // Behavioural adder: answers after UNIT_LAT request cycles, holds ready until request falls.
  int unit_cnt;
  always @(posedge i_clock) begin
    if (!i_reset) begin
      bus.i_unit_ready  <= 1'b0;
      bus.i_unit_result <= 32'd0;
      unit_cnt          <= 0;
    end else if (bus.i_unit_ready) begin
      if (!bus.o_unit_request) bus.i_unit_ready <= 1'b0;
    end else if (bus.o_unit_request) begin
      if (unit_cnt == UNIT_LAT - 1) begin
        bus.i_unit_ready  <= 1'b1;
        bus.i_unit_result <= r2f(f2r(bus.o_unit_op1) + f2r(bus.o_unit_op2));
        unit_cnt          <= 0;
      end else begin
        unit_cnt <= unit_cnt + 1;
      end
    end else begin
      unit_cnt <= 0;
    end
  end

  always @(negedge i_clock) begin
    if (i_reset) begin
      checks++;
      if ($countones(bus.o_ready) > 1) begin
        failures++;
        $display("[TB] FAIL ready_onehot actual=%b required=at most one bit", bus.o_ready);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [REQUESTERS-1:0] oh;
    bit got;
    oh  = REQUESTERS'(1) << v.client;
    got = 1'b0;
    @(negedge i_clock);
    bus.i_op1[32*v.client +: 32] = v.op1;
    bus.i_op2[32*v.client +: 32] = v.op2;
    bus.i_sub[v.client]          = v.sub;
    bus.i_request[v.client]      = 1'b1;
    @(posedge i_clock); #1;
    checkOutput("grant_unit_request", 32'(bus.o_unit_request), 32'd1);
    checkOutput("grant_unit_op1", bus.o_unit_op1, v.op1);
    checkOutput("grant_unit_op2", bus.o_unit_op2, v.exp_op2);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge i_clock);
      if (bus.i_unit_ready) got = 1'b1;
    end
    checkOutput("unit_ready_seen", 32'(got), 32'd1);
    @(negedge i_clock);
    checkOutput("done_ready", 32'(bus.o_ready), 32'(oh));
    checkOutput("done_result", bus.o_result, v.exp_result);
    @(negedge i_clock);
    checkOutput("hold_ready", 32'(bus.o_ready), 32'(oh));
    checkOutput("hold_result", bus.o_result, v.exp_result);
    bus.i_request[v.client] = 1'b0;
    @(posedge i_clock); #1;
    checkOutput("release_ready", 32'(bus.o_ready), 32'd0);
    repeat (3) @(negedge i_clock);
  endtask

  // Each client re-raises its request the cycle after it drops, for n operations each.
  task automatic runClients(input int n0, input int n1);
    int rem[2];
    logic [31:0] exp_res[2];
    rem[0] = n0;
    rem[1] = n1;
    exp_res[0] = 32'h4000_0000;
    exp_res[1] = 32'h4040_0000;
    order_q.delete();
    bus.i_op1 = {32'h4000_0000, 32'h3F80_0000};
    bus.i_op2 = {32'h3F80_0000, 32'h3F80_0000};
    bus.i_sub = '0;
    for (int cyc = 0; cyc < 400 && (rem[0] > 0 || rem[1] > 0 || bus.i_request != '0); cyc++) begin
      @(negedge i_clock);
      for (int k = 0; k < 2; k++) begin
        if (bus.i_request[k] && bus.o_ready[k]) begin
          order_q.push_back(k);
          checkOutput("clients_result", bus.o_result, exp_res[k]);
          checkOutput("clients_unit_req_low", 32'(bus.o_unit_request), 32'd0);
          bus.i_request[k] = 1'b0;
          rem[k]--;
        end else if (!bus.i_request[k] && rem[k] > 0) begin
          bus.i_request[k] = 1'b1;
        end
      end
    end
    checkOutput("clients_outstanding", 32'(rem[0] + rem[1]), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"}, 32'(bus.o_ready), 32'd0);
    checkOutput({tag, "_result"}, bus.o_result, 32'd0);
    checkOutput({tag, "_unit_request"}, 32'(bus.o_unit_request), 32'd0);
    checkOutput({tag, "_unit_op1"}, bus.o_unit_op1, 32'd0);
    checkOutput({tag, "_unit_op2"}, bus.o_unit_op2, 32'd0);
  endtask

  initial begin
    bit seen_ready;
    vecs[0] = '{0, 1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h4040_0000};
    vecs[1] = '{1, 1'b1, 32'h4040_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000};
    vecs[2] = '{0, 1'b1, 32'h3F80_0000, 32'h4040_0000, 32'hC040_0000, 32'hC000_0000};
    vecs[3] = '{1, 1'b0, 32'h40A0_0000, 32'hBFC0_0000, 32'hBFC0_0000, 32'h4060_0000};
    vecs[4] = '{0, 1'b1, 32'h4000_0000, 32'hC000_0000, 32'h4000_0000, 32'h4080_0000};
    exp_order = '{0, 1, 0, 1, 0, 1};

    bus.i_request = '0;
    bus.i_sub     = '0;
    bus.i_op1     = '0;
    bus.i_op2     = '0;
    repeat (3) @(negedge i_clock);
    checkResetOutputs("reset");
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Simultaneous requests straight after reset: client 0 must go first.
    @(negedge i_clock);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b1;
    runClients(1, 1);
    checkOutput("simul_count", 32'(order_q.size()), 32'd2);
    for (int i = 0; i < order_q.size() && i < 2; i++)
      checkOutput("simul_order", 32'(order_q[i]), 32'(exp_order[i]));
    repeat (3) @(negedge i_clock);

    runClients(3, 3);
    checkOutput("b2b_count", 32'(order_q.size()), 32'd6);
    for (int i = 0; i < order_q.size() && i < 6; i++)
      checkOutput("b2b_order", 32'(order_q[i]), 32'(exp_order[i]));
    repeat (3) @(negedge i_clock);

    // Client 0 abandons its request while the adder is busy.
    bus.i_op1[31:0] = 32'h3F80_0000;
    bus.i_op2[31:0] = 32'h3F80_0000;
    bus.i_sub[0]    = 1'b0;
    bus.i_request[0] = 1'b1;
    @(negedge i_clock);
    checkOutput("abandon_granted", 32'(bus.o_unit_request), 32'd1);
    bus.i_request[0] = 1'b0;
    seen_ready = 1'b0;
    repeat (12) begin
      @(negedge i_clock);
      if (bus.o_ready != '0) seen_ready = 1'b1;
    end
    checkOutput("abandon_no_ready", 32'(seen_ready), 32'd0);
    checkOutput("abandon_unit_req_low", 32'(bus.o_unit_request), 32'd0);
    applyStimulus(vecs[3]);

    // Reset in the middle of WAIT_UNIT clears everything; a fresh request still works.
    bus.i_op1[31:0] = 32'h3F80_0000;
    bus.i_op2[31:0] = 32'h4000_0000;
    bus.i_request[0] = 1'b1;
    @(negedge i_clock);
    checkOutput("midreset_granted", 32'(bus.o_unit_request), 32'd1);
    @(negedge i_clock);
    i_reset = 1'b0;
    bus.i_request[0] = 1'b0;
    @(posedge i_clock); #1;
    checkResetOutputs("midreset");
    @(negedge i_clock);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);
    applyStimulus(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/cpu_fpu_add_arbiter.md
# cpu_fpu_add_arbiter

Round-robin arbiter sharing one multi-cycle single-precision FPU adder among REQUESTERS clients (e.g. CPU execute stage and a vector/DMA helper). Each client runs the codebase's level handshake: raise request with operands, hold until ready, drop request. The arbiter latches the winner's operands, sequences the adder through its request/ready handshake, and returns the result. It optionally negates op2 to provide subtraction.

## Interface
- REQUESTERS, 2: number of clients, 2..8.
- i_clock  in  1  sole clock, rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_request  in  REQUESTERS  per-client request level.
- i_sub  in  REQUESTERS  per-client: 1 = op1 - op2, sampled with operands.
- i_op1  in  32*REQUESTERS  client k operand at [32k+31:32k].
- i_op2  in  32*REQUESTERS  as i_op1.
- o_ready  out  REQUESTERS  per-client done level; at most one bit set.
- o_result  out  32  result for the client whose o_ready is set.
- o_unit_request  out  1  request to adder.
- o_unit_op1  out  32  latched op1.
- o_unit_op2  out  32  latched op2, bit 31 inverted when sub.
- i_unit_ready  in  1  adder done level.
- i_unit_result  in  32  adder result.

## Operation
- Reset (i_reset=0 at a clock edge): state IDLE; o_ready=0, o_result=0, o_unit_request=0, o_unit_op1/op2=0; last-grant pointer = REQUESTERS-1, so client 0 wins first. The adder shares this reset (inverted at instantiation); the arbiter never resumes an in-flight operation.
- States: IDLE, WAIT_UNIT, RESPOND, DRAIN.
- IDLE: if any i_request bit set and i_unit_ready=0: grant first set bit scanning last+1, last+2, ... modulo REQUESTERS; register grant and pointer; latch op1, op2 (op2[31] ^= i_sub[g]); o_unit_request<=1; go WAIT_UNIT. If i_unit_ready=1, stay IDLE.
- WAIT_UNIT: hold o_unit_request=1 and operands stable. On i_unit_ready=1: o_result<=i_unit_result; o_unit_request<=0; if i_request[g]=1, set o_ready[g] and go RESPOND, else go DRAIN (abandoned request; result discarded, no o_ready).
- RESPOND: hold o_ready[g] and o_result. When i_request[g]=0: o_ready<=0; go DRAIN.
- DRAIN: when i_unit_ready=0, go IDLE. This guarantees the next grant never sees a stale adder ready.
- o_result retains its last value outside RESPOND; only meaningful while o_ready is set.
- Operand bits beyond sign are passed unchanged; NaN inputs with sub get their sign flipped, which does not matter since the adder returns canonical NaN.
- Non-granted requests wait, holding their operands; they are never lost. Operand changes by a waiting client are taken at grant time only.

## Timing
- Grant: request sampled in IDLE at edge N gives o_unit_request=1 after edge N. The adder sees it at edge N+1.
- Completion: i_unit_ready high at edge M gives o_ready[g]=1 and o_result valid after edge M. The arbiter adds 1 cycle each way.
- Release: client drops request at edge R. o_ready=0 after R. DRAIN lasts until the adder ready falls, which is already low in the normal case. So IDLE is entered after R+1 and the next grant is issued after R+2 at the earliest.
- Back-to-back: with two clients continuously requesting, grants alternate 0,1,0,1. A client holding i_request high through RESPOND keeps o_ready high; it must drop to start a new operation.
- Simultaneous new requests in IDLE: round-robin order decides. The grant pointer updates only on grant.
- Reset asserted in any state takes priority over all transitions that cycle.

## Test plan
- Client 0 issues 0x3F800000 + 0x40000000, sub=0 -> unit sees same operands; o_ready[0]=1 with o_result=0x40400000; o_ready[1] stays 0.
- Client 1 issues 0x40400000, 0x3F800000, sub=1 -> o_unit_op2=0xBF800000; o_result=0x40000000 on o_ready[1].
- Both clients request in the same cycle straight after reset -> client 0 served first, client 1 second. o_unit_request low for at least one cycle between them; never two o_ready bits set.
- Both clients re-request immediately after each release for 6 operations -> grant order 0,1,0,1,0,1; each result matches its own operands (client k uses op1=k+1.0, op2=1.0).
- Client 0 drops request during WAIT_UNIT -> no o_ready pulse; arbiter passes DRAIN; a subsequent client 1 request completes correctly.
- Reset asserted mid-WAIT_UNIT -> next cycle all outputs 0, state IDLE; a fresh request completes with the correct result.
